regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_wb_arbiter_if.sv | 25 ++
 rtl/wb_skid_fifo.sv | 52 +++++
 rtl/regfile_wb_arbiter.sv | 63 ++++++
 tb/tb_regfile_wb_arbiter.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths and the write-request record.
package regfile_pkg;
    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: WB stage, multi-cycle unit and register-file write port signals.
interface regfile_wb_arbiter_if;
    import regfile_pkg::*;
    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_data;
    logic                  mc_valid;
    logic [REG_ADDR_W-1:0] mc_rd;
    logic [XLEN-1:0]       mc_data;
    logic                  mc_ready;
    logic                  RegWrite;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       Write_Data;
    logic [NUM_REGS-1:0]   pend_mask;
    logic                  stall_req;

    modport master (
        output wb_valid, wb_rd, wb_data, mc_valid, mc_rd, mc_data,
        input  mc_ready, RegWrite, rd, Write_Data, pend_mask, stall_req
    );
    modport slave (
        input  wb_valid, wb_rd, wb_data, mc_valid, mc_rd, mc_data,
        output mc_ready, RegWrite, rd, Write_Data, pend_mask, stall_req
    );
endinterface

// File: rtl/wb_skid_fifo.sv
// wb_skid_fifo: circular buffer for multi-cycle results; storage is not reset,
// only pointers and count are, and per-entry liveness is exported for mask decode.
module wb_skid_fifo
    import regfile_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  wb_req_t          din,
    input  logic             pop,
    output wb_req_t          dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output wb_req_t          entries [DEPTH],
    output logic [DEPTH-1:0] live
);
    logic [PW-1:0] rd_ptr, wr_ptr;
    wb_req_t       mem [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout    = mem[rd_ptr];
    assign entries = mem;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;

    // An entry is live when its distance from the head is below the occupancy.
    for (genvar i = 0; i < DEPTH; i++) begin : g_live
        logic [PW-1:0] off;
        assign off     = PW'(i) - rd_ptr;
        assign live[i] = CW'(off) < count;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between pipeline WB
// (always wins) and buffered multi-cycle results; exports pending mask and stall hint.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input logic                 clock,
    input logic                 reset,
    regfile_wb_arbiter_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(MAX_WAIT + 1);

    logic             wb_own, push, pop, full, empty;
    logic [CW-1:0]    count;
    logic [AW-1:0]    age;
    logic [DEPTH-1:0] live;
    wb_req_t          head;
    wb_req_t          entries [DEPTH];
    logic [NUM_REGS-1:0] mask;

    assign wb_own = bus.wb_valid && bus.wb_rd != '0;
    assign pop    = !wb_own && !empty;
    // Handshakes to x0 are accepted but never stored.
    assign push   = bus.mc_valid && !full && bus.mc_rd != '0;

    wb_skid_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .din     ('{rd: bus.mc_rd, data: bus.mc_data}),
        .pop     (pop),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .entries (entries),
        .live    (live)
    );

    always_comb begin
        bus.mc_ready   = count != CW'(DEPTH);
        bus.RegWrite   = wb_own || !empty;
        bus.rd         = wb_own ? bus.wb_rd : empty ? '0 : head.rd;
        bus.Write_Data = wb_own ? bus.wb_data : empty ? '0 : head.data;
        bus.stall_req  = age == AW'(MAX_WAIT) && !empty;
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < DEPTH; i++)
            if (live[i]) mask[entries[i].rd] = 1'b1;
        bus.pend_mask = {mask[NUM_REGS-1:1], 1'b0};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) age <= '0;
        else if (empty || pop) age <= '0;
        else if (wb_own && age != AW'(MAX_WAIT)) age <= age + 1'b1;
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed plus random stimulus against a queue-based
// reference model; a negedge monitor pops expected status/writes and compares.
module tb_regfile_wb_arbiter;
    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;

    typedef struct {
        logic        we;
        logic        ready;
        logic [31:0] mask;
        logic        stall;
    } stat_t;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } wr_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    stat_t sq[$];
    wr_t   wq[$];
    wr_t   model_q[$];
    int    age    = 0;
    int    passed = 0;
    int    total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    stat_t s;
    wr_t   w;
    always @(negedge clock) begin
        if (sq.size() > 0) begin
            s = sq.pop_front();
            check("mc_ready", 64'(bus.mc_ready), 64'(s.ready));
            check("pend_mask", 64'(bus.pend_mask), 64'(s.mask));
            check("stall_req", 64'(bus.stall_req), 64'(s.stall));
            check("RegWrite", 64'(bus.RegWrite), 64'(s.we));
            if (bus.RegWrite) begin
                if (wq.size() > 0) begin
                    w = wq.pop_front();
                    check("write_rd", 64'(bus.rd), 64'(w.rd));
                    check("write_data", bus.Write_Data, w.data);
                end else begin
                    check("spurious_write", 64'(bus.RegWrite), 64'(0));
                end
            end else begin
                check("idle_rd", 64'(bus.rd), 64'(0));
                check("idle_data", bus.Write_Data, 64'(0));
            end
        end
    end

    // Drive one cycle, record what the model expects of it, then advance the model past the edge.
    task automatic cycle(input logic wv, input logic [4:0] wrd, input logic [63:0] wd,
                         input logic mv, input logic [4:0] mrd, input logic [63:0] md);
        logic        own, rdy, we;
        logic [31:0] m;
        bus.wb_valid = wv;
        bus.wb_rd    = wrd;
        bus.wb_data  = wd;
        bus.mc_valid = mv;
        bus.mc_rd    = mrd;
        bus.mc_data  = md;
        own = wv && wrd != 0;
        rdy = model_q.size() < DEPTH;
        m   = '0;
        foreach (model_q[i]) m[model_q[i].rd] = 1'b1;
        we  = own || model_q.size() > 0;
        if (own) wq.push_back('{wrd, wd});
        else if (model_q.size() > 0) wq.push_back(model_q[0]);
        sq.push_back('{we, rdy, m, (age == MAX_WAIT) && model_q.size() > 0});
        @(posedge clock);
        #1;
        if (model_q.size() == 0) age = 0;
        else if (!own) begin
            void'(model_q.pop_front());
            age = 0;
        end else if (age < MAX_WAIT) age++;
        if (mv && rdy && mrd != 0) model_q.push_back('{mrd, md});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        bus.wb_valid = 0;
        bus.wb_rd    = 0;
        bus.wb_data  = 0;
        bus.mc_valid = 0;
        bus.mc_rd    = 0;
        bus.mc_data  = 0;
        model_q.delete();
        age = 0;
        sq.push_back('{1'b0, 1'b1, 32'h0, 1'b0});
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        bus.wb_valid = 0;
        bus.wb_rd    = 0;
        bus.wb_data  = 0;
        bus.mc_valid = 0;
        bus.mc_rd    = 0;
        bus.mc_data  = 0;
        @(posedge clock);
        #1;
        do_reset();
        idle(1);
        // Idle port: accepted then written next cycle
        cycle(0, 0, 0, 1, 7, 64'hAA);
        idle(2);
        // Contention with continuous WB to x3
        cycle(1, 3, 64'h31, 1, 5, 64'h55);
        cycle(1, 3, 64'h32, 1, 6, 64'h66);
        cycle(1, 3, 64'h33, 1, 9, 64'h99);
        for (int i = 0; i < 5; i++) cycle(1, 3, 64'h40 + 64'(i), 0, 0, 0);
        idle(3);
        // x0 handling
        cycle(0, 0, 0, 1, 12, 64'hC0FFEE);
        cycle(1, 0, 64'hDEAD, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 64'hBAD);
        idle(2);
        // Full buffer with simultaneous offer, then wrap
        cycle(1, 4, 64'h1, 1, 10, 64'hA10);
        cycle(1, 4, 64'h2, 1, 11, 64'hA11);
        cycle(0, 0, 0, 1, 13, 64'hA13);
        cycle(0, 0, 0, 1, 13, 64'hA13);
        for (int i = 0; i < 10; i++)
            cycle(i[0], 5'd8, rnd64(), 1, 5'(14 + i), rnd64());
        idle(4);
        // Reset mid-operation
        cycle(1, 2, 64'h22, 1, 20, 64'h2020);
        cycle(1, 2, 64'h23, 1, 21, 64'h2121);
        do_reset();
        idle(3);
        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            int p;
            p = ((i / 150) % 2) ? 90 : 40;
            if ($urandom_range(0, 299) == 0) do_reset();
            else cycle($urandom_range(0, 99) < p,
                       ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                       rnd64(),
                       $urandom_range(0, 99) < 50,
                       ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                       rnd64());
        end
        idle(4);
        @(negedge clock);
        #1;
        check("writes_drained", 64'(wq.size()), 64'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
